alu_mdu_seq: RTL

- Parametrised, multi-cycle execute unit that succeeds the single-cycle combinational ALU in the RISC-V datapath.
- Performs the existing integer ALU operations with one cycle of latency.
- Adds the RV32M multiply/divide family, computed iteratively at one bit per cycle.
- Uses a valid/ready handshake on input and output so the pipeline control can stall on it. Supports a flush for squashed instructions.

---
 rtl/alu_mdu_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu_seq.sv
// Multi-cycle execute unit: one-cycle integer ALU ops plus iterative RV32M
// multiply (shift-add) and divide (restoring), one bit per cycle.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one multiply/divide step per cycle, DATA_WIDTH steps
// FIXUP | sign correction and half/quotient/remainder select
// DONE  | result valid, waiting for out_ready
module alu_mdu_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;

    logic [4:0]      op5;
    logic            accept, is_iter;
    logic [W-1:0]    alu_res;
    logic [SHW-1:0]  shamt;
    logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, neg_res;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    div_sel, fix_res;

    assign op5     = Operation[4:0];
    assign accept  = in_valid && in_ready && !flush;
    assign is_iter = op5[4] && !op5[3];
    assign shamt   = SrcB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        if (!op5[4]) begin
            case (op5[3:0])
                4'b0000: alu_res = SrcA & SrcB;
                4'b0001: alu_res = SrcA | SrcB;
                4'b0010: alu_res = SrcA + SrcB;
                4'b0011: alu_res = SrcA ^ SrcB;
                4'b0110: alu_res = SrcA - SrcB;
                4'b0100: alu_res = W'(SrcA < SrcB);
                4'b1000: alu_res = W'(SrcA == SrcB);
                4'b1100: alu_res = W'($signed(SrcA) < $signed(SrcB));
                4'b1101: alu_res = SrcA << shamt;
                4'b1110: alu_res = SrcA >> shamt;
                4'b1111: alu_res = $signed(SrcA) >>> shamt;
                default: alu_res = '0;
            endcase
        end
    end

    // Operands are iterated as magnitudes; the result sign is restored in FIXUP.
    // A zero divisor keeps the quotient positive so DIV by 0 stays all-ones.
    always_comb begin
        a_sgn   = (op5[2:0] == 3'b001) || (op5[2:0] == 3'b010) ||
                  (op5[2:0] == 3'b100) || (op5[2:0] == 3'b110);
        b_sgn   = (op5[2:0] == 3'b001) || (op5[2:0] == 3'b100) || (op5[2:0] == 3'b110);
        a_neg   = a_sgn && SrcA[W-1];
        b_neg   = b_sgn && SrcB[W-1];
        a_mag   = a_neg ? -SrcA : SrcA;
        b_mag   = b_neg ? -SrcB : SrcB;
        b_zero  = (SrcB == '0);
        case (op5[2:0])
            3'b001:  neg_res = a_neg ^ b_neg;
            3'b010:  neg_res = a_neg;
            3'b100:  neg_res = (a_neg ^ b_neg) && !b_zero;
            3'b110:  neg_res = a_neg;
            default: neg_res = 1'b0;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
        div_shift = {acc_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        prod      = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
        div_sel   = op_q[1] ? acc_q : lo_q;
        if (op_q[2]) begin
            fix_res = neg_q ? -div_sel : div_sel;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        op_d    = op5[2:0];
                        neg_d   = neg_res;
                        cnt_d   = '0;
                        acc_d   = '0;
                        lo_d    = op5[2] ? a_mag : b_mag;
                        opb_d   = op5[2] ? b_mag : a_mag;
                        state_d = CALC;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    if (!div_diff[W]) begin
                        acc_d = div_diff[W-1:0];
                        lo_d  = {lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[W-1:0];
                        lo_d  = {lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[W:1];
                    lo_d  = {mul_sum[0], lo_q[W-1:1]};
                end
                if (cnt_q == LAST_STEP) state_d = FIXUP;
            end
            FIXUP: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == FIXUP);
    assign ALUResult = result_q;
endmodule
